// File: rtl/ray_stepper.sv
// ray_stepper: walks a ray from an origin along a fixed direction and emits one
// position per accepted output beat.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid / in_ready       job handshake (accepted only while idle)
//   org_x/y/z [19:0]          signed ray origin
//   dir_x/y/z [TARGET-1:0]    signed per-step direction
//   num_steps [CW-1:0]        number of positions to emit (0 = no beats)
//   out_valid / out_ready     position beat handshake
//   pos_x/y/z [19:0]          signed current position
//   out_idx   [CW-1:0]        beat index, starting at 0
//   out_last                  final beat of the job
//   out_ovf                   job ended early because the next position overflows
module ray_stepper #(
  parameter int TARGET = 9,
  parameter int CW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       org_x,
  input  logic [19:0]       org_y,
  input  logic [19:0]       org_z,
  input  logic [TARGET-1:0] dir_x,
  input  logic [TARGET-1:0] dir_y,
  input  logic [TARGET-1:0] dir_z,
  input  logic [CW-1:0]     num_steps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [19:0]       pos_x,
  output logic [19:0]       pos_y,
  output logic [19:0]       pos_z,
  output logic [CW-1:0]     out_idx,
  output logic              out_last,
  output logic              out_ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [19:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d, pos_z_q, pos_z_d;
  logic [TARGET-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
  logic [CW-1:0]     idx_q, idx_d, num_q, num_d;

  // Next-position sums at 21 bits: the two top bits disagree exactly when the
  // result falls outside the 20-bit signed range.
  logic [20:0] sum_x, sum_y, sum_z;
  logic        ovf, at_end, running, accept;

  always_comb begin
    sum_x = {pos_x_q[19], pos_x_q} + {{(21-TARGET){dir_x_q[TARGET-1]}}, dir_x_q};
    sum_y = {pos_y_q[19], pos_y_q} + {{(21-TARGET){dir_y_q[TARGET-1]}}, dir_y_q};
    sum_z = {pos_z_q[19], pos_z_q} + {{(21-TARGET){dir_z_q[TARGET-1]}}, dir_z_q};
    ovf   = (sum_x[20] ^ sum_x[19]) | (sum_y[20] ^ sum_y[19]) | (sum_z[20] ^ sum_z[19]);
  end

  assign running   = (state_q == RUN);
  // num_q is non-zero whenever RUN is entered, so the decrement cannot wrap there.
  assign at_end    = (idx_q == num_q - CW'(1));
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = running;
  assign out_last  = running && (at_end || ovf);
  assign out_ovf   = running && ovf && !at_end;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_z     = pos_z_q;
  assign out_idx   = idx_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    pos_z_d = pos_z_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    dir_z_d = dir_z_q;
    idx_d   = idx_q;
    num_d   = num_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_x_d = dir_x;
          dir_y_d = dir_y;
          dir_z_d = dir_z;
          num_d   = num_steps;
          pos_x_d = org_x;
          pos_y_d = org_y;
          pos_z_d = org_z;
          idx_d   = '0;
          // A zero-length job is absorbed without leaving IDLE.
          state_d = (num_steps != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (out_last) begin
            // Position is left untouched, so an overflowed sum is never loaded.
            state_d = IDLE;
          end else begin
            pos_x_d = sum_x[19:0];
            pos_y_d = sum_y[19:0];
            pos_z_d = sum_z[19:0];
            idx_d   = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including latched job data, is reset so outputs read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      pos_z_q <= '0;
      dir_x_q <= '0;
      dir_y_q <= '0;
      dir_z_q <= '0;
      idx_q   <= '0;
      num_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      pos_z_q <= pos_z_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      dir_z_q <= dir_z_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
    end
  end

endmodule

// File: tb/tb_ray_stepper.sv
// tb_ray_stepper: directed, table-driven bench for ray_stepper. Each table row
// is one job with its hand-computed beat sequence; a few hand-written sequences
// cover zero-length jobs, idle out_ready and reset mid-job.
module tb_ray_stepper;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic signed [19:0] org_x, org_y, org_z;
  logic signed [8:0]  dir_x, dir_y, dir_z;
  logic [7:0]        num_steps;
  logic              out_valid, out_ready;
  logic signed [19:0] pos_x, pos_y, pos_z;
  logic [7:0]        out_idx;
  logic              out_last, out_ovf;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ray_stepper #(.TARGET(9), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .org_x(org_x), .org_y(org_y), .org_z(org_z),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
    .num_steps(num_steps),
    .out_valid(out_valid), .out_ready(out_ready),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .out_idx(out_idx), .out_last(out_last), .out_ovf(out_ovf)
  );

  typedef struct packed {
    logic signed [19:0] x, y, z;
    logic [7:0]         idx;
    logic               last, ovf;
  } beat_t;

  typedef struct {
    logic signed [19:0] ox, oy, oz;
    logic signed [8:0]  dx, dy, dz;
    logic [7:0]         n;
    bit                 stall;  // toggle out_ready every cycle
    bit                 noise;  // keep in_valid high with other data during RUN
    int                 nb;
    beat_t [3:0]        b;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void set_job(input int i, input int ox, input int oy, input int oz,
                                  input int dx, input int dy, input int dz, input int n,
                                  input bit stall, input bit noise);
    vecs[i].ox = 20'(ox); vecs[i].oy = 20'(oy); vecs[i].oz = 20'(oz);
    vecs[i].dx = 9'(dx);  vecs[i].dy = 9'(dy);  vecs[i].dz = 9'(dz);
    vecs[i].n = 8'(n); vecs[i].stall = stall; vecs[i].noise = noise;
    vecs[i].nb = 0;
    vecs[i].b = '0;
  endfunction

  function automatic void add_beat(input int i, input int x, input int y, input int z,
                                   input int idx, input bit last, input bit ovf);
    beat_t bt;
    bt.x = 20'(x); bt.y = 20'(y); bt.z = 20'(z);
    bt.idx = 8'(idx); bt.last = last; bt.ovf = ovf;
    vecs[i].b[vecs[i].nb] = bt;
    vecs[i].nb++;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int    k, guard;
    bit    ph, stalled;
    beat_t held, cur;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " in_ready before job"}, longint'(in_ready), 1);
    org_x = v.ox; org_y = v.oy; org_z = v.oz;
    dir_x = v.dx; dir_y = v.dy; dir_z = v.dz;
    num_steps = v.n;
    in_valid  = 1'b1;
    out_ready = !v.stall;
    @(negedge clk);
    if (v.noise) begin
      org_x = 20'sd12345; org_y = -20'sd777; org_z = 20'sd1;
      dir_x = 9'sd7; dir_y = 9'sd7; dir_z = 9'sd7; num_steps = 8'd9;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, " out_valid latency 1"}, longint'(out_valid), 1);
    k = 0; guard = 0; stalled = 0; ph = 0;
    while (k < v.nb && guard < 100) begin
      cur = {pos_x, pos_y, pos_z, out_idx, out_last, out_ovf};
      if (stalled) begin
        check({tag, " stall valid"}, longint'(out_valid), 1);
        check({tag, " stall hold"}, longint'(cur == held), 1);
      end
      if (v.stall) begin
        out_ready = ph;
        ph = ~ph;
      end
      if (out_valid && out_ready) begin
        check($sformatf("%s b%0d x", tag, k), longint'(pos_x), longint'(v.b[k].x));
        check($sformatf("%s b%0d y", tag, k), longint'(pos_y), longint'(v.b[k].y));
        check($sformatf("%s b%0d z", tag, k), longint'(pos_z), longint'(v.b[k].z));
        check($sformatf("%s b%0d idx", tag, k), longint'(out_idx), longint'(v.b[k].idx));
        check($sformatf("%s b%0d last", tag, k), longint'(out_last), longint'(v.b[k].last));
        check($sformatf("%s b%0d ovf", tag, k), longint'(out_ovf), longint'(v.b[k].ovf));
        if (v.b[k].last) in_valid = 1'b0;
        k++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held    = cur;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check({tag, " beat count"}, longint'(k), longint'(v.nb));
    check({tag, " no extra beat"}, longint'(out_valid), 0);
    check({tag, " in_ready after job"}, longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    // Row 0: basic walk; row 1: same with stalls; row 2: +x overflow;
    // row 3: count terminates before overflow; row 4: zero direction;
    // row 5: -y reaching -2^19 exactly, then overflowing; row 6: RUN ignores in_valid.
    set_job(0, 0, 0, 0, 1, -2, 3, 3, 0, 0);
    add_beat(0, 0, 0, 0, 0, 0, 0);
    add_beat(0, 1, -2, 3, 1, 0, 0);
    add_beat(0, 2, -4, 6, 2, 1, 0);
    set_job(1, 0, 0, 0, 1, -2, 3, 3, 1, 0);
    add_beat(1, 0, 0, 0, 0, 0, 0);
    add_beat(1, 1, -2, 3, 1, 0, 0);
    add_beat(1, 2, -4, 6, 2, 1, 0);
    set_job(2, 524280, 0, 0, 5, 0, 0, 10, 0, 0);
    add_beat(2, 524280, 0, 0, 0, 0, 0);
    add_beat(2, 524285, 0, 0, 1, 1, 1);
    set_job(3, -524288, 0, 0, -256, 255, -1, 1, 0, 0);
    add_beat(3, -524288, 0, 0, 0, 1, 0);
    set_job(4, 7, -9, 100, 0, 0, 0, 3, 1, 0);
    add_beat(4, 7, -9, 100, 0, 0, 0);
    add_beat(4, 7, -9, 100, 1, 0, 0);
    add_beat(4, 7, -9, 100, 2, 1, 0);
    set_job(5, 3, -524280, 0, 0, -8, 1, 5, 0, 0);
    add_beat(5, 3, -524280, 0, 0, 0, 0);
    add_beat(5, 3, -524288, 1, 1, 1, 1);
    set_job(6, 100, 200, -300, -1, 2, -3, 2, 0, 1);
    add_beat(6, 100, 200, -300, 0, 0, 0);
    add_beat(6, 99, 202, -303, 1, 1, 0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    org_x = '0; org_y = '0; org_z = '0;
    dir_x = '0; dir_y = '0; dir_z = '0; num_steps = '0;

    // Reset state
    @(negedge clk);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset in_ready", longint'(in_ready), 0);
    check("reset pos_x", longint'(pos_x), 0);
    check("reset out_idx", longint'(out_idx), 0);
    check("reset out_last", longint'(out_last), 0);
    check("reset out_ovf", longint'(out_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", longint'(in_ready), 1);

    // out_ready in IDLE does nothing
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle out_ready valid", longint'(out_valid), 0);
    check("idle out_ready in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Zero-length job, followed by a 2-step job
    org_x = 20'sd50; org_y = '0; org_z = '0;
    dir_x = 9'sd1; dir_y = '0; dir_z = '0; num_steps = 8'd0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero job out_valid", longint'(out_valid), 0);
    check("zero job in_ready", longint'(in_ready), 1);
    @(negedge clk);
    check("zero job still idle", longint'(out_valid), 0);
    set_job(0, -5, 6, -7, 2, -3, 4, 2, 0, 0);
    add_beat(0, -5, 6, -7, 0, 0, 0);
    add_beat(0, -3, 3, -3, 1, 1, 0);
    run_vec(vecs[0], "after zero");

    // Reset pulsed during beat idx1 of a 5-step job
    org_x = 20'sd10; org_y = 20'sd20; org_z = 20'sd30;
    dir_x = 9'sd1; dir_y = 9'sd1; dir_z = 9'sd1; num_steps = 8'd5;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst job idx0", longint'(out_idx), 0);
    @(negedge clk);
    check("rst job idx1", longint'(out_idx), 1);
    check("rst job x1", longint'(pos_x), 11);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", longint'(out_valid), 0);
    check("mid-reset pos_x", longint'(pos_x), 0);
    check("mid-reset pos_z", longint'(pos_z), 0);
    check("mid-reset out_idx", longint'(out_idx), 0);
    check("mid-reset in_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post mid-reset out_valid", longint'(out_valid), 0);
    check("post mid-reset in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;
    run_vec(vecs[1], "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ray_stepper.md
RAY_STEPPER -- requirements
Module: ray_stepper

Interface
REQ-001 SHALL have parameter: TARGET, 9, width of the signed direction components.
REQ-002 SHALL have parameter: CW, 8, width of the step counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  job request valid.
REQ-006 in_ready  output  1  block can accept a job.
REQ-007 org_x, org_y, org_z  input  20 each  signed ray origin.
REQ-008 dir_x, dir_y, dir_z  input  TARGET each  signed ray direction, already contained to TARGET bits.
REQ-009 num_steps  input  CW  number of positions to emit for the job.
REQ-010 out_valid  output  1  position beat valid.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 pos_x, pos_y, pos_z  output  20 each  signed current position.
REQ-013 out_idx  output  CW  index of the current beat, starting at 0.
REQ-014 out_last  output  1  final beat of the job.
REQ-015 out_ovf  output  1  job terminated by coordinate overflow; valid only with out_last.

Function
REQ-016 SHALL implement states IDLE and RUN; in_ready = 1 only in IDLE with rst_n high.
REQ-017 On in_valid && in_ready, SHALL latch dir_*, num_steps; load pos_* with org_*; clear out_idx.
REQ-018 Accepted job with num_steps = 0: SHALL stay in IDLE, emit no beat, and be ready again the next cycle.
REQ-019 Accepted job with num_steps > 0: SHALL enter RUN; out_valid high from the cycle after acceptance (latency 1); first beat is pos = origin, out_idx = 0.
REQ-020 In RUN, out_valid SHALL stay 1, and pos_*, out_idx, out_last, out_ovf SHALL stay stable while out_ready = 0.
REQ-021 On out_valid && out_ready with out_last = 0: pos_* += sign-extended dir_*, out_idx += 1, in the same edge.
REQ-022 Next-position sums SHALL be computed at 21 bits; overflow = any sum outside [-2^19, 2^19-1].
REQ-023 out_last SHALL be 1 when out_idx = num_steps-1 or the next position overflows; out_ovf = 1 only when overflow holds and out_idx != num_steps-1.
REQ-024 On handshake with out_last = 1: SHALL return to IDLE and drop out_valid the next cycle; an output position SHALL never hold an overflowed value.
REQ-025 Direction (0,0,0) SHALL be legal: emits num_steps identical positions.
REQ-026 in_valid while in RUN SHALL be ignored; no job queuing, no back-to-back overlap.
REQ-027 out_ready during IDLE SHALL have no effect.

Reset
REQ-028 rst_n low SHALL force, asynchronously: state IDLE, out_valid 0, in_ready 0, pos_* 0, out_idx 0, out_last 0, out_ovf 0, latched dir/count 0.
REQ-029 Reset asserted mid-job SHALL abort it with no further beats; after release the block SHALL be in IDLE with in_ready 1.

Verification
REQ-030 org (0,0,0), dir (1,-2,3), num_steps 3, out_ready 1 -> beats (0,0,0) idx0, (1,-2,3) idx1, (2,-4,6) idx2 with last=1, ovf=0; in_ready 1 on the following cycle.
REQ-031 Same job, out_ready toggled 0/1 every cycle -> identical beat sequence; outputs unchanged across each stalled cycle.
REQ-032 org (524280,0,0), dir (5,0,0), num_steps 10 -> beats x=524280, 524285 (last=1, ovf=1, idx1); no third beat.
REQ-033 num_steps 0 -> no out_valid; in_ready high again one cycle after acceptance; a following job of 2 steps runs normally.
REQ-034 org (-524288,0,0), dir (-256,255,-1), num_steps 1 -> single beat at origin, last=1, ovf=0 (count terminates first).
REQ-035 rst_n pulsed low during beat idx1 of a 5-step job -> out_valid 0 immediately, all outputs 0, in_ready 1 after release, new job accepted.
